// File: rtl/dsp_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_pkg
// Brief    : Shared state encoding, OPMODE values and CE bit map for dsp_mac_seq.
// Revision : 1.0
// ============================================================================
package dsp_mac_pkg;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLR    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESULT = 3'd4;

    localparam logic [7:0] OPM_FIRST  = 8'h01;
    localparam logic [7:0] OPM_ACC    = 8'h09;
    localparam int         PREADD_BIT = 4;

    localparam int CE_A       = 7;
    localparam int CE_B       = 6;
    localparam int CE_M       = 5;
    localparam int CE_C       = 4;
    localparam int CE_D       = 3;
    localparam int CE_CARRYIN = 2;
    localparam int CE_OPMODE  = 1;
    localparam int CE_P       = 0;

    function automatic logic [7:0] opm_sel(input logic first, input logic preadd);
        logic [7:0] v;
        v = first ? OPM_FIRST : OPM_ACC;
        v[PREADD_BIT] = preadd;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mac_flag_dly.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_flag_dly
// Brief    : DEPTH-stage shift register of {vld, first} tracking samples in the slice.
// Revision : 1.0
// ============================================================================
module dsp_mac_flag_dly #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_vld,
    input  logic shift_first,
    output logic opm_vld,
    output logic opm_first,
    output logic p_vld,
    output logic empty
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-2:0] r_first;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_vld   <= '0;
            r_first <= '0;
        end else begin
            r_vld   <= {r_vld[DEPTH-2:0], shift_vld};
            r_first <= {r_first[DEPTH-3:0], shift_first};
        end
    end

    // OPMODE is registered in the slice one stage ahead of the P register
    assign opm_vld   = r_vld[DEPTH-2];
    assign opm_first = r_first[DEPTH-2];
    assign p_vld     = r_vld[DEPTH-1];
    assign empty     = ~|r_vld;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq
// Brief    : N-sample signed MAC sequencer for an external dsp slice.
//            Define DSP_MAC_PREADD_EN to add in_d and use (D+B)*A products.
// Revision : 1.0
// ============================================================================
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int ABD_WIDTH    = 18,
    parameter int CP_WIDTH     = 48,
    parameter int OPMODE_WIDTH = 8,
    parameter int LEN_WIDTH    = 16,
    parameter int DSP_LAT      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ABD_WIDTH-1:0]    in_a,
    input  logic [ABD_WIDTH-1:0]    in_b,
`ifdef DSP_MAC_PREADD_EN
    input  logic [ABD_WIDTH-1:0]    in_d,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CP_WIDTH-1:0]     out_p,
    output logic                    out_carry,
    output logic                    busy,
    output logic [ABD_WIDTH-1:0]    dsp_a,
    output logic [ABD_WIDTH-1:0]    dsp_b,
    output logic [ABD_WIDTH-1:0]    dsp_d,
    output logic [CP_WIDTH-1:0]     dsp_c,
    output logic [OPMODE_WIDTH-1:0] dsp_opmode,
    output logic                    dsp_carryin,
    output logic [7:0]              dsp_ce,
    output logic                    dsp_rst,
    input  logic [CP_WIDTH-1:0]     dsp_p,
    input  logic                    dsp_carryout
);

`ifdef DSP_MAC_PREADD_EN
    localparam logic C_PREADD = 1'b1;
    assign dsp_d = in_d;
`else
    localparam logic C_PREADD = 1'b0;
    assign dsp_d = '0;
`endif

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_opm_vld;
    logic                 w_opm_first;
    logic                 w_p_vld;
    logic                 w_empty;

    assign w_hs        = in_valid & in_ready;
    assign w_last      = (r_cnt == r_len - LEN_WIDTH'(1));
    assign dsp_a       = in_a;
    assign dsp_b       = in_b;
    assign dsp_c       = '0;
    assign dsp_carryin = 1'b0;

    dsp_mac_flag_dly #(
        .DEPTH (DSP_LAT)
    ) u_flag_dly (
        .clk         (CLK),
        .rst         (RST),
        .clr         (r_state == ST_CLR),
        .shift_vld   (w_hs),
        .shift_first (r_cnt == '0),
        .opm_vld     (w_opm_vld),
        .opm_first   (w_opm_first),
        .p_vld       (w_p_vld),
        .empty       (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = (cfg_len == '0) ? ST_RESULT : ST_CLR;
            ST_CLR:    w_next = ST_RUN;
            ST_RUN:    if (w_hs && w_last) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_empty) w_next = ST_RESULT;
            ST_RESULT: if (out_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        dsp_rst   = 1'b0;
        case (r_state)
            ST_IDLE:   dsp_rst   = 1'b1;
            ST_CLR:    dsp_rst   = 1'b1;
            ST_RUN:    in_ready  = (r_cnt != r_len);
            ST_RESULT: out_valid = 1'b1;
            default:   ;
        endcase
        dsp_ce             = '0;
        dsp_ce[CE_A]       = w_hs;
        dsp_ce[CE_B]       = w_hs;
        dsp_ce[CE_M]       = w_hs;
        dsp_ce[CE_D]       = w_hs & C_PREADD;
        dsp_ce[CE_OPMODE]  = w_opm_vld;
        dsp_ce[CE_P]       = w_p_vld;
        dsp_opmode = w_opm_vld ? OPMODE_WIDTH'(opm_sel(w_opm_first, C_PREADD)) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_len     <= '0;
            r_cnt     <= '0;
            out_p     <= '0;
            out_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len <= cfg_len;
                        r_cnt <= '0;
                        if (cfg_len == '0) begin
                            out_p     <= '0;
                            out_carry <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) r_cnt <= r_cnt + LEN_WIDTH'(1);
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        out_p     <= dsp_p;
                        out_carry <= dsp_carryout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
